// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote, false-start
// rejection, framing-error pulse. Define UART_RX_PARITY_EN to add a parity bit and rx_perr_o.
module uart_rx_os16 #(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200,
  parameter int c_stopbit  = 1
`ifdef UART_RX_PARITY_EN
  , parameter bit c_parity_odd = 1'b0
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_dout_o,
  output logic       rx_done_tick_o,
  output logic       rx_ferr_o,
`ifdef UART_RX_PARITY_EN
  output logic       rx_perr_o,
`endif
  output logic       rx_busy_o
);

  localparam int c_ticklim = c_clkfreq / (c_baudrate * 16);
  localparam int c_divw    = (c_ticklim > 1) ? $clog2(c_ticklim) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_nx;
  logic              rx_meta, rxs;
  logic [c_divw-1:0] div_cnt;
  logic              tick;
  logic [3:0]        s_cnt;
  logic [2:0]        samp;
  logic              s2_eff, maj;
  logic              armed;
  logic [2:0]        bit_idx;
  logic              stop_idx, final_stop;
  logic [7:0]        sreg;
  logic              start_det, shift_en, stop_inc, done_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
  logic              par_chk, par_err;
`endif

  assign tick       = (div_cnt == c_divw'(c_ticklim - 1));
  assign final_stop = (stop_idx == 1'(c_stopbit - 1));
  // The final stop bit is decided on the s_cnt=9 tick, before the third sample is registered.
  assign s2_eff     = (s_cnt == 4'd9) ? rxs : samp[2];
  assign maj        = (samp[0] & samp[1]) | (samp[0] & s2_eff) | (samp[1] & s2_eff);
  assign rx_busy_o  = (state != S_IDLE);

  // NOTE: every clocked process uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= S_IDLE;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      state   <= state_nx;
    end
  end

  // NOTE: all always_comb outputs get a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    stop_inc  = 1'b0;
    done_nx   = 1'b0;
    ferr_nx   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (armed && !rxs) begin
          start_det = 1'b1;
          state_nx  = S_START;
        end
      end
      S_START: begin
        if (tick && s_cnt == 4'd15) state_nx = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && s_cnt == 4'd15) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_nx = S_PARITY;
`else
          if (bit_idx == 3'd7) state_nx = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && s_cnt == 4'd15) begin
          par_chk  = 1'b1;
          state_nx = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (final_stop && s_cnt == 4'd9) begin
            state_nx = S_IDLE;
            done_nx  = maj;
            ferr_nx  = !maj;
          end else if (!final_stop && s_cnt == 4'd15) begin
            if (!maj) begin
              ferr_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              stop_inc = 1'b1;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Divider and bit-phase counter restart on the start edge so samples land mid-bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      s_cnt    <= '0;
      samp     <= '0;
      armed    <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      sreg     <= '0;
    end else begin
      if (start_det) begin
        div_cnt <= '0;
        s_cnt   <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        s_cnt   <= s_cnt + 4'd1;
      end else begin
        div_cnt <= div_cnt + c_divw'(1);
      end

      if (tick) begin
        case (s_cnt)
          4'd7:    samp[0] <= rxs;
          4'd8:    samp[1] <= rxs;
          4'd9:    samp[2] <= rxs;
          default: ;
        endcase
      end

      if (start_det)                 armed <= 1'b0;
      else if (state == S_IDLE && rxs) armed <= 1'b1;

      if (start_det) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else begin
        if (shift_en) bit_idx  <= bit_idx + 3'd1;
        if (stop_inc) stop_idx <= 1'b1;
      end

      if (shift_en) sreg <= {maj, sreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_err <= 1'b0;
    end else if (start_det) begin
      par_err <= 1'b0;
    end else if (par_chk) begin
      par_err <= ((^sreg) ^ maj) != c_parity_odd;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_dout_o      <= '0;
      rx_done_tick_o <= 1'b0;
      rx_ferr_o      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_perr_o      <= 1'b0;
`endif
    end else begin
      rx_done_tick_o <= done_nx;
      rx_ferr_o      <= ferr_nx;
`ifdef UART_RX_PARITY_EN
      rx_perr_o      <= (done_nx | ferr_nx) & par_err;
      if (done_nx && !par_err) rx_dout_o <= sreg;
`else
      if (done_nx) rx_dout_o <= sreg;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16 at 32 clk/bit: expected frame outcomes are queued when
// driven and matched against done/ferr pulses by a monitor sampling on the falling edge.
module tb_uart_rx_os16;

  localparam int c_bit = 32;

  typedef struct packed {
    logic       is_ferr;
    logic [7:0] data;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] rx_dout_o;
  logic       rx_done_tick_o;
  logic       rx_ferr_o;
  logic       rx_busy_o;
`ifdef UART_RX_PARITY_EN
  logic       rx_perr_o;
`endif

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         chk_gap  = 1'b0;

  uart_rx_os16 #(
    .c_clkfreq (32_000_000),
    .c_baudrate(1_000_000),
    .c_stopbit (1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .rx_dout_o     (rx_dout_o),
    .rx_done_tick_o(rx_done_tick_o),
    .rx_ferr_o     (rx_ferr_o),
`ifdef UART_RX_PARITY_EN
    .rx_perr_o     (rx_perr_o),
`endif
    .rx_busy_o     (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard and last exactly one cycle.
  always @(negedge clk_i) begin
    if (chk_gap) check("pulse_one_cycle", {30'd0, rx_done_tick_o, rx_ferr_o}, 32'd0);
    chk_gap <= 1'b0;
    if (!rst_i && (rx_done_tick_o || rx_ferr_o)) begin
      chk_gap <= 1'b1;
      check("done_ferr_exclusive", {31'd0, rx_done_tick_o & rx_ferr_o}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_done_tick_o, rx_ferr_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind_ferr", {31'd0, rx_ferr_o}, {31'd0, e.is_ferr});
        if (!e.is_ferr) check("rx_dout", {24'd0, rx_dout_o}, {24'd0, e.data});
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  // glitch_bit >= 0 inverts clocks 16..17 of that data bit, hitting only the first sample.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_clks,
                            input int glitch_bit);
    drive_bit(1'b0, c_bit);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], 16);
        drive_bit(~d[i], 2);
        drive_bit(d[i], c_bit - 18);
      end else begin
        drive_bit(d[i], c_bit);
      end
    end
    drive_bit(stop_v, stop_clks);
  endtask

  task automatic expect_done(input logic [7:0] d);
    sb_q.push_back('{is_ferr: 1'b0, data: d});
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) @(negedge clk_i);
    check("sb_drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (4) @(negedge clk_i);
    check("reset_dout", {24'd0, rx_dout_o}, 32'd0);
    check("reset_done", {31'd0, rx_done_tick_o}, 32'd0);
    check("reset_ferr", {31'd0, rx_ferr_o}, 32'd0);
    check("reset_busy", {31'd0, rx_busy_o}, 32'd0);
    rst_i = 1'b0;
    drive_bit(1'b1, 64);

    // 1: single frame, busy must drop within 18 clocks of the stop-bit centre.
    expect_done(8'h55);
    send_frame(8'h55, 1'b1, 16, -1);
    for (int k = 0; k < 18 && rx_busy_o; k++) @(negedge clk_i);
    check("busy_fall_18", {31'd0, rx_busy_o}, 32'd0);
    wait_drain(64);
    drive_bit(1'b1, 32);

    // 2: back-to-back frames with no idle gap.
    expect_done(8'hA3);
    expect_done(8'h0F);
    send_frame(8'hA3, 1'b1, c_bit, -1);
    send_frame(8'h0F, 1'b1, c_bit, -1);
    wait_drain(64);
    drive_bit(1'b1, 32);

    // 3: short low glitch is a false start.
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 2);
    check("glitch_busy_high", {31'd0, rx_busy_o}, 32'd1);
    drive_bit(1'b1, 30);
    check("glitch_busy_low", {31'd0, rx_busy_o}, 32'd0);
    check("glitch_dout_kept", {24'd0, rx_dout_o}, 32'h0F);
    drive_bit(1'b1, 32);

    // 5: single-sample glitch in data bit 3 is voted out.
    expect_done(8'h00);
    send_frame(8'h00, 1'b1, c_bit, 3);
    wait_drain(64);
    drive_bit(1'b1, 32);

    // 4: framing error followed by a long break, then a clean frame.
    sb_q.push_back('{is_ferr: 1'b1, data: 8'h00});
    send_frame(8'h3C, 1'b0, c_bit, -1);
    drive_bit(1'b0, 100);
    check("ferr_reported", sb_q.size(), 32'd0);
    check("break_no_start", {31'd0, rx_busy_o}, 32'd0);
    drive_bit(1'b0, 20 * c_bit - 100);
    check("break_still_idle", {31'd0, rx_busy_o}, 32'd0);
    check("ferr_dout_kept", {24'd0, rx_dout_o}, 32'h00);
    drive_bit(1'b1, 64);
    expect_done(8'h81);
    send_frame(8'h81, 1'b1, c_bit, -1);
    wait_drain(64);
    drive_bit(1'b1, 32);

    // 6: reset in the middle of data bit 4 aborts the frame silently.
    drive_bit(1'b0, c_bit);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, c_bit);
    drive_bit(1'b1, 16);
    check("pre_reset_busy", {31'd0, rx_busy_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("midreset_dout", {24'd0, rx_dout_o}, 32'd0);
    check("midreset_busy", {31'd0, rx_busy_o}, 32'd0);
    check("midreset_done", {31'd0, rx_done_tick_o}, 32'd0);
    check("midreset_ferr", {31'd0, rx_ferr_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    drive_bit(1'b1, 64);
    expect_done(8'h7E);
    send_frame(8'h7E, 1'b1, c_bit, -1);
    wait_drain(64);
    drive_bit(1'b1, 32);

    check("final_queue_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
